bus_mux_reg: RTL and testbench
==============================

# bus_mux_reg

Parametrised registered bus multiplexer for the datapath: NSRC sources of WIDTH bits, each with a one-hot drive select, are encoded and merged onto a single registered bus output. It generalises the previous combinational 24-source bus mux, adding a pipelined output, a configurable idle policy, multiple-driver conflict detection with a sticky flag and a saturating counter, and an index report of the granted source. It sits between the register file / special registers (PC, MDR, InPort, HI, LO, ZHI, ZLO, C) and every bus consumer.

## Interface
- WIDTH, 32, bus and source data width (1..64)
- NSRC, 24, number of bus sources (2..64)
- HOLD_IDLE, 1, 1: bus holds last value when no select asserted; 0: bus drives zero
- CNT_W, 8, width of conflict counter
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- src_data  in  NSRC*WIDTH  flattened source data; source i at bits [i*WIDTH +: WIDTH]
- src_sel  in  NSRC  drive selects, one-hot expected; bit i = source i
- err_clr  in  1  synchronous clear of conflict flag and counter
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  registered: a source was granted in the previous cycle
- grant_idx  out  $clog2(NSRC)  registered index of the granted source
- conflict  out  1  sticky: two or more selects seen asserted in one cycle
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Each cycle: priority-encode src_sel; lowest asserted index i wins.
- Winner present: next bus_out = source i data, bus_valid = 1, grant_idx = i.
- No select: bus_valid = 0; grant_idx holds; bus_out holds (HOLD_IDLE=1) or loads 0 (HOLD_IDLE=0).
- Conflict = popcount(src_sel) >= 2; the lowest-index source still drives (no bus corruption).
- On a conflict cycle: conflict set to 1, conflict_cnt increments, saturates at 2^CNT_W-1 (no wrap).
- err_clr = 1 without conflict that cycle: conflict = 0, conflict_cnt = 0.
- err_clr = 1 with conflict the same cycle: conflict = 1, conflict_cnt = 1 (new event wins over clear).
- err_clr has no effect on bus_out, bus_valid, grant_idx.
- Reset (clr = 0), any time including mid-transfer: bus_out = 0, bus_valid = 0, grant_idx = 0, conflict = 0, conflict_cnt = 0; takes effect immediately, independent of clk.
- After release, first rising edge with clr = 1 samples normally; no extra warm-up cycles.

## Timing
- Latency: src_sel/src_data sampled at edge N, reflected on bus_out/bus_valid/grant_idx after edge N; one cycle, fixed.
- Back-to-back selects of different sources every cycle: bus_out changes every cycle, no bubbles.
- conflict and conflict_cnt update at the same edge as the bus.
- All outputs driven directly from flops; no combinational path from inputs to outputs.
- Reset assertion asynchronous; deassertion assumed synchronised upstream to clk.

## Configuration
- BUS_MUX_PARITY_EN defined: extra output bus_par (1 bit), registered alongside bus_out, equal to XOR of all bus_out bits (even parity); reset value 0; follows bus_out under HOLD_IDLE rules.
- Not defined: port bus_par absent, no parity logic; all other behaviour identical.

## Test plan
- Reset: drive clr = 0 mid-run with src_sel = 1<<5 -> all outputs 0 immediately, before next clk edge; release, next edge -> bus_out = source 5 data, grant_idx = 5.
- Single select: NSRC=24, WIDTH=32, src i data = i+1, PC at index 16 = 32'h11111111; src_sel = 1<<0 -> bus_out = 32'h00000001 one cycle later; src_sel = 1<<16 -> 32'h11111111, grant_idx = 16.
- Idle: select R5 (32'h00000006) then src_sel = 0 -> HOLD_IDLE=1: bus_out stays 32'h00000006, bus_valid = 0; HOLD_IDLE=0: bus_out = 0.
- Conflict: src_sel = (1<<3)|(1<<7) -> bus_out = 32'h00000004, grant_idx = 3, conflict = 1, conflict_cnt = 1; hold 300 cycles with CNT_W=8 -> conflict_cnt saturates at 255.
- Clear race: err_clr = 1 with src_sel one-hot -> conflict = 0, cnt = 0; err_clr = 1 same cycle as two selects -> conflict = 1, cnt = 1.
- Parity (BUS_MUX_PARITY_EN): select 32'h00000007 -> bus_par = 1; select 32'h88888888 -> bus_par = 0; without macro, bench compiles with bus_par unconnected removed.

Source files
------------

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered NSRC-to-1 bus multiplexer with lowest-index
// priority, a selectable idle policy, multiple-driver conflict detection
// (sticky flag plus saturating counter) and a report of the granted index.
// Optional feature: define BUS_MUX_PARITY_EN to add the registered even-parity
// output bus_par. When the macro is undefined, the port and its logic are absent.
module bus_mux_reg #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 24,
  parameter int HOLD_IDLE = 1,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NSRC*WIDTH-1:0]  src_data,
  input  logic [NSRC-1:0]        src_sel,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [IDX_W-1:0]       grant_idx,
`ifdef BUS_MUX_PARITY_EN
  output logic                   bus_par,
`endif
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam logic [NSRC-1:0]  SEL_ONE = {{(NSRC-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Lowest asserted select, isolated as a one-hot mask (x & -x).
  logic [NSRC-1:0]  sel_low;
  logic             sel_any;
  logic             sel_multi;
  logic [WIDTH-1:0] masked_data [NSRC];
  logic [WIDTH-1:0] win_data;
  logic [IDX_W-1:0] win_idx;

  assign sel_low   = src_sel & (~src_sel + SEL_ONE);
  assign sel_any   = |src_sel;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign sel_multi = |(src_sel & (src_sel - SEL_ONE));

  // Gate each source by its share of the one-hot winner mask.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_mask
      assign masked_data[gi] = src_data[gi*WIDTH +: WIDTH] & {WIDTH{sel_low[gi]}};
    end
  endgenerate

  // OR-merge the masked sources; at most one is non-zero.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      win_data = win_data | masked_data[i];
    end
  end

  // Priority encoder: scanning downward lets the lowest asserted index win.
  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_sel[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  logic [WIDTH-1:0] bus_reg, bus_next;
  logic             valid_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             conflict_reg, conflict_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Next bus value: winner's data, otherwise hold or zero depending on idle policy.
  always_comb begin
    bus_next = '0;
    if (sel_any) begin
      bus_next = win_data;
    end else if (HOLD_IDLE != 0) begin
      bus_next = bus_reg;
    end
  end

  // Conflict bookkeeping: a new event outranks a simultaneous clear.
  always_comb begin
    conflict_next = conflict_reg;
    cnt_next      = cnt_reg;
    if (sel_multi) begin
      conflict_next = 1'b1;
      if (err_clr) begin
        cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (err_clr) begin
      conflict_next = 1'b0;
      cnt_next      = '0;
    end
  end

  // Output bus, valid and granted index registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_reg   <= '0;
      valid_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      bus_reg   <= bus_next;
      valid_reg <= sel_any;
      if (sel_any) begin
        idx_reg <= win_idx;
      end
    end
  end

  // Sticky conflict flag and saturating conflict counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      conflict_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      conflict_reg <= conflict_next;
      cnt_reg      <= cnt_next;
    end
  end

`ifdef BUS_MUX_PARITY_EN
  logic par_reg;

  // Even parity of the value being loaded into the bus register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      par_reg <= 1'b0;
    end else begin
      par_reg <= ^bus_next;
    end
  end

  assign bus_par = par_reg;
`endif

  assign bus_out      = bus_reg;
  assign bus_valid    = valid_reg;
  assign grant_idx    = idx_reg;
  assign conflict     = conflict_reg;
  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed-vector bench for bus_mux_reg (NSRC=24, WIDTH=32). Two instances
// share the stimulus: dut uses the holding idle policy, dut_z drives zero.
module tb_bus_mux_reg;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int CNT_W = 8;
  localparam int IDX_W = $clog2(NSRC);

  logic                  clk = 1'b0;
  logic                  clr;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_sel;
  logic                  err_clr;

  logic [WIDTH-1:0] bus_out, bus_out_z;
  logic             bus_valid, bus_valid_z;
  logic [IDX_W-1:0] grant_idx, grant_idx_z;
  logic             conflict, conflict_z;
  logic [CNT_W-1:0] conflict_cnt, conflict_cnt_z;
`ifdef BUS_MUX_PARITY_EN
  logic             bus_par, bus_par_z;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_IDLE(1), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .clr          (clr),
    .src_data     (src_data),
    .src_sel      (src_sel),
    .err_clr      (err_clr),
    .bus_out      (bus_out),
    .bus_valid    (bus_valid),
    .grant_idx    (grant_idx),
`ifdef BUS_MUX_PARITY_EN
    .bus_par      (bus_par),
`endif
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_IDLE(0), .CNT_W(CNT_W)) dut_z (
    .clk          (clk),
    .clr          (clr),
    .src_data     (src_data),
    .src_sel      (src_sel),
    .err_clr      (err_clr),
    .bus_out      (bus_out_z),
    .bus_valid    (bus_valid_z),
    .grant_idx    (grant_idx_z),
`ifdef BUS_MUX_PARITY_EN
    .bus_par      (bus_par_z),
`endif
    .conflict     (conflict_z),
    .conflict_cnt (conflict_cnt_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Source i carries i+1, except PC at 16 and a parity pattern at 20.
    for (int i = 0; i < NSRC; i++) begin
      src_data[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    end
    src_data[16*WIDTH +: WIDTH] = 32'h11111111;
    src_data[20*WIDTH +: WIDTH] = 32'h88888888;

    clr     = 1'b0;
    src_sel = '0;
    err_clr = 1'b0;
    #1;
    check("rst bus_out",   64'(bus_out), 64'h0);
    check("rst bus_valid", 64'(bus_valid), 64'h0);
    check("rst grant_idx", 64'(grant_idx), 64'h0);
    check("rst conflict",  64'(conflict), 64'h0);
    check("rst cnt",       64'(conflict_cnt), 64'h0);
    #12;
    clr = 1'b1;

    // Single selects, back to back.
    src_sel = 24'(1 << 0);
    tick();
    check("sel0 bus_out",   64'(bus_out), 64'h00000001);
    check("sel0 bus_valid", 64'(bus_valid), 64'h1);
    check("sel0 grant_idx", 64'(grant_idx), 64'd0);

    src_sel = 24'(1 << 16);
    tick();
    check("sel16 bus_out",   64'(bus_out), 64'h11111111);
    check("sel16 grant_idx", 64'(grant_idx), 64'd16);

    src_sel = 24'(1 << 5);
    tick();
    check("sel5 bus_out",   64'(bus_out), 64'h00000006);
    check("sel5 grant_idx", 64'(grant_idx), 64'd5);
    check("sel5 z bus_out", 64'(bus_out_z), 64'h00000006);

    // Idle: holding instance keeps R5, zeroing instance drops to 0.
    src_sel = '0;
    tick();
    check("idle bus_out",     64'(bus_out), 64'h00000006);
    check("idle bus_valid",   64'(bus_valid), 64'h0);
    check("idle grant_idx",   64'(grant_idx), 64'd5);
    check("idle z bus_out",   64'(bus_out_z), 64'h0);
    check("idle z bus_valid", 64'(bus_valid_z), 64'h0);

    // Conflict: lowest index still drives.
    src_sel = 24'((1 << 3) | (1 << 7));
    tick();
    check("conf bus_out",   64'(bus_out), 64'h00000004);
    check("conf grant_idx", 64'(grant_idx), 64'd3);
    check("conf flag",      64'(conflict), 64'h1);
    check("conf cnt",       64'(conflict_cnt), 64'd1);
    check("conf valid",     64'(bus_valid), 64'h1);

    // 300 conflict cycles in total: counter saturates at 255.
    for (int k = 0; k < 299; k++) begin
      tick();
    end
    check("sat cnt",  64'(conflict_cnt), 64'd255);
    check("sat flag", 64'(conflict), 64'h1);

    // Clear with a clean one-hot select.
    err_clr = 1'b1;
    src_sel = 24'(1 << 2);
    tick();
    check("clr flag",    64'(conflict), 64'h0);
    check("clr cnt",     64'(conflict_cnt), 64'd0);
    check("clr bus_out", 64'(bus_out), 64'h00000003);
    check("clr idx",     64'(grant_idx), 64'd2);

    // Clear racing a new conflict: the event wins.
    src_sel = 24'((1 << 1) | (1 << 9));
    tick();
    check("race flag",    64'(conflict), 64'h1);
    check("race cnt",     64'(conflict_cnt), 64'd1);
    check("race bus_out", 64'(bus_out), 64'h00000002);
    check("race idx",     64'(grant_idx), 64'd1);

    // Flag is sticky once the clear is released.
    err_clr = 1'b0;
    src_sel = 24'(1 << 6);
    tick();
    check("sticky flag", 64'(conflict), 64'h1);
    check("sticky cnt",  64'(conflict_cnt), 64'd1);
    check("sel6 bus_out", 64'(bus_out), 64'h00000007);
`ifdef BUS_MUX_PARITY_EN
    check("par 07", 64'(bus_par), 64'h1);
`endif

    src_sel = 24'(1 << 20);
    tick();
    check("sel20 bus_out", 64'(bus_out), 64'h88888888);
`ifdef BUS_MUX_PARITY_EN
    check("par 88888888", 64'(bus_par), 64'h0);
`endif

    // Asynchronous reset mid-cycle with source 5 selected.
    src_sel = 24'(1 << 5);
    #2;
    clr = 1'b0;
    #1;
    check("arst bus_out",   64'(bus_out), 64'h0);
    check("arst bus_valid", 64'(bus_valid), 64'h0);
    check("arst grant_idx", 64'(grant_idx), 64'h0);
    check("arst conflict",  64'(conflict), 64'h0);
    check("arst cnt",       64'(conflict_cnt), 64'h0);
    #2;
    clr = 1'b1;
    tick();
    check("rel bus_out",   64'(bus_out), 64'h00000006);
    check("rel grant_idx", 64'(grant_idx), 64'd5);
    check("rel bus_valid", 64'(bus_valid), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
